fpu_wb_scheduler: RTL
=====================

Name: fpu_wb_scheduler

Overview:
- Parametrised successor to the fixed 3-stage FPU writeback controller.
- Tracks in-flight float ops issued to fadd/fmul/finv/fsqrt, each with its own latency, and schedules their register-file writebacks on a shift-register slot ring.
- Stalls issue on writeback-port collisions and on RAW/WAW hazards against pending float destinations.
- Sits between decode and the float register file; the arithmetic units are external and feed their results in.

Parameters:
- LAT_ADD, 3, fadd/fsub latency in clocks (1..MAX_LAT)
- LAT_MUL, 3, fmul/fmuln latency (1..MAX_LAT)
- LAT_INV, 3, finv latency (1..MAX_LAT)
- LAT_SQRT, 3, fsqrt latency (1..MAX_LAT)
- MAX_LAT, 8, number of schedule slots; must be >= every LAT_*
- NREG, 32, float register count; address width is clog2(NREG)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction may be accepted this cycle (combinational)
- op  in  6  inst[31:26]
- rd  in  clog2(NREG)  destination, inst[15:11]
- rs_addr  in  clog2(NREG)  source A register
- rt_addr  in  clog2(NREG)  source B register
- negate_b  out  1  op[0] of a valid FPU op; selects negated rt into the adder/multiplier
- flush  in  1  synchronous kill of all in-flight ops
- fadd_res, fmul_res, finv_res, fsqrt_res  in  32 each  unit outputs
- wb_enable  out  1  write the float register file this cycle
- wb_addr  out  clog2(NREG)  writeback register
- wb_data  out  32  writeback data
- wb_float  out  1  constant 1
- pending  out  NREG  per-register in-flight bitmap (debug and verification)

Behaviour:
- Op decode:
  - 110000/110001 → ADD, latency LAT_ADD.
  - 110010/110011 → MUL, latency LAT_MUL.
  - 110100 → INV, latency LAT_INV.
  - 110101 → SQRT, latency LAT_SQRT.
  - Any other op is non-FPU: issue_ready=1, nothing is scheduled.
- Operand B hazard: SQRT and INV ignore rt_addr in hazard checks.
- Slot ring: MAX_LAT slots, each holding {valid, addr, src[1:0]}.
  - Every clock, slot[i] ← slot[i+1]; the top slot ← empty.
  - wb_enable = slot[0].valid; wb_addr = slot[0].addr.
  - wb_data = the unit result selected by slot[0].src, else 0 when wb_enable=0.
- issue_fire = issue_valid & is_fpu & issue_ready.
  - On fire: slot[L-1] is written {1, rd, src} on the same edge the shift occurs, with precedence over the shifted value.
  - Result: wb_enable is high exactly L cycles after the fire edge. L=3 reproduces the legacy timing.
- issue_ready = 0 for an FPU op if any of the following holds:
  - the post-shift target slot (current slot[L]) is valid, i.e. a writeback-port collision;
  - pending[rs_addr], pending[rd], or (for ADD/MUL) pending[rt_addr] is set.
  - Otherwise issue_ready = 1.
  - issue_ready does not depend on issue_valid.
- Pending bitmap:
  - Set on fire for rd.
  - Cleared on the edge ending the cycle in which wb_enable=1 for that addr.
  - The bit is still set during the writeback cycle itself, so issue of a dependent op stalls that cycle (no bypass).
  - Same-edge set and clear of one register cannot occur, because rd pending blocks issue.
- flush:
  - On the next edge, all slots and the pending bitmap clear.
  - issue_ready is forced to 0 during the flush cycle, so nothing is accepted.
  - wb_enable in the flush cycle still reflects slot[0]; that write completes.
- Reset (rst_n=0, asynchronous):
  - All slots invalid, pending=0.
  - Hence wb_enable=0, wb_addr=0, wb_data=0.
  - Reset mid-operation discards all in-flight ops; no late writebacks appear after release.
- Mixed latencies:
  - A long op issued before a short one may write back later; ordering is by completion, not issue.
  - Collisions are resolved only by stalling the younger op, never by reordering.
- Assertions (simulation only): LAT_* in 1..MAX_LAT; no two ops ever share a slot.

Test Plan:
- Defaults, fadd rd=5 at edge 0 → wb_enable=1, wb_addr=5, wb_data=fadd_res in cycle 3 only; pending[5] is high in cycles 1–3 and low in cycle 4.
- LAT_SQRT=6, LAT_ADD=3; fsqrt rd=1 at cycle 0, fadd rd=2 at cycle 3 → fadd stalls at cycle 3 (slot collision, issue_ready=0); accepted at cycle 4; writebacks at cycle 6 (r1) and cycle 7 (r2).
- fmul rd=7, then fadd rs=7 next cycle → issue_ready=0 through the writeback cycle of r7; fadd accepted the cycle after.
- fsqrt with rt_addr=pending reg 9, rs clear → issue_ready=1 (rt ignored); fsub sets negate_b=1; fadd sets negate_b=0.
- Three ops in flight, flush pulsed → at most the current slot[0] write occurs; thereafter wb_enable=0 and pending=0; issue_ready=0 during the flush cycle.
- rst_n low for 1 cycle with 2 ops in flight → outputs are immediately 0; no wb_enable for 10 cycles after release; non-FPU op (op=000000) always sees issue_ready=1.

Source files
------------

// File: rtl/fpu_wb_scheduler_if.sv
// Decode-side issue handshake, unit result inputs and float register-file
// writeback bundle for fpu_wb_scheduler.
interface fpu_wb_scheduler_if #(
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            issue_valid;
  logic            issue_ready;
  logic [5:0]      op;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rs_addr;
  logic [AW-1:0]   rt_addr;
  logic            negate_b;
  logic            flush;
  logic [31:0]     fadd_res;
  logic [31:0]     fmul_res;
  logic [31:0]     finv_res;
  logic [31:0]     fsqrt_res;
  logic            wb_enable;
  logic [AW-1:0]   wb_addr;
  logic [31:0]     wb_data;
  logic            wb_float;
  logic [NREG-1:0] pending;

  modport master (
    output issue_valid, op, rd, rs_addr, rt_addr, flush,
           fadd_res, fmul_res, finv_res, fsqrt_res,
    input  issue_ready, negate_b, wb_enable, wb_addr, wb_data, wb_float, pending
  );

  modport slave (
    input  issue_valid, op, rd, rs_addr, rt_addr, flush,
           fadd_res, fmul_res, finv_res, fsqrt_res,
    output issue_ready, negate_b, wb_enable, wb_addr, wb_data, wb_float, pending
  );
endinterface

// File: rtl/fpu_wb_scheduler.sv
// Float writeback scheduler: per-unit latencies on a shifting slot ring, with
// issue stalls on writeback-port collisions and RAW/WAW hazards.
module fpu_wb_scheduler #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_INV  = 3,
  parameter int unsigned LAT_SQRT = 3,
  parameter int unsigned MAX_LAT  = 8,
  parameter int unsigned NREG     = 32
) (
  input logic               clk,
  input logic               rst_n,
  fpu_wb_scheduler_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {
    SRC_ADD  = 2'd0,
    SRC_MUL  = 2'd1,
    SRC_INV  = 2'd2,
    SRC_SQRT = 2'd3
  } src_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    src_e          src;
  } slot_t;

  slot_t           slot_q [MAX_LAT];
  slot_t           slot_d [MAX_LAT];
  logic [NREG-1:0] pending_q, pending_d;

  logic        is_fpu, uses_rt, collide, hazard, issue_ready, issue_fire;
  src_e        src;
  int unsigned lat;

  always_comb begin
    is_fpu  = 1'b0;
    uses_rt = 1'b0;
    src     = SRC_ADD;
    lat     = 0;
    case (bus.op)
      6'b110000, 6'b110001: begin is_fpu = 1'b1; uses_rt = 1'b1; src = SRC_ADD;  lat = LAT_ADD;  end
      6'b110010, 6'b110011: begin is_fpu = 1'b1; uses_rt = 1'b1; src = SRC_MUL;  lat = LAT_MUL;  end
      6'b110100:            begin is_fpu = 1'b1;                 src = SRC_INV;  lat = LAT_INV;  end
      6'b110101:            begin is_fpu = 1'b1;                 src = SRC_SQRT; lat = LAT_SQRT; end
      default: ;
    endcase
  end

  // slot[L] is what lands in slot[L-1] after this edge's shift; L == MAX_LAT
  // targets the top slot, which is always refilled empty.
  always_comb begin
    collide = 1'b0;
    for (int unsigned i = 0; i < MAX_LAT; i++) begin
      if (i == lat && slot_q[i].valid) collide = 1'b1;
    end
    hazard = pending_q[bus.rs_addr] | pending_q[bus.rd] |
             (uses_rt & pending_q[bus.rt_addr]);
    issue_ready = !bus.flush && !(is_fpu && (collide || hazard));
    issue_fire  = bus.issue_valid && is_fpu && issue_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i + 1 < MAX_LAT; i++) slot_d[i] = slot_q[i+1];
    slot_d[MAX_LAT-1] = '0;
    if (issue_fire) begin
      for (int unsigned i = 0; i < MAX_LAT; i++) begin
        if (i + 1 == lat) slot_d[i] = '{valid: 1'b1, addr: bus.rd, src: src};
      end
    end

    pending_d = pending_q;
    if (slot_q[0].valid) pending_d[slot_q[0].addr] = 1'b0;
    if (issue_fire)      pending_d[bus.rd]         = 1'b1;

    if (bus.flush) begin
      for (int unsigned i = 0; i < MAX_LAT; i++) slot_d[i] = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LAT; i++) slot_q[i] <= '0;
      pending_q <= '0;
    end else begin
      for (int unsigned i = 0; i < MAX_LAT; i++) slot_q[i] <= slot_d[i];
      pending_q <= pending_d;
    end
  end

  always_comb begin
    bus.issue_ready = issue_ready;
    bus.negate_b    = is_fpu & bus.op[0];
    bus.wb_enable   = slot_q[0].valid;
    bus.wb_addr     = slot_q[0].valid ? slot_q[0].addr : '0;
    bus.wb_float    = 1'b1;
    bus.pending     = pending_q;
    bus.wb_data     = '0;
    if (slot_q[0].valid) begin
      case (slot_q[0].src)
        SRC_ADD:  bus.wb_data = bus.fadd_res;
        SRC_MUL:  bus.wb_data = bus.fmul_res;
        SRC_INV:  bus.wb_data = bus.finv_res;
        SRC_SQRT: bus.wb_data = bus.fsqrt_res;
        default:  bus.wb_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (LAT_ADD  >= 1 && LAT_ADD  <= MAX_LAT);
      assert (LAT_MUL  >= 1 && LAT_MUL  <= MAX_LAT);
      assert (LAT_INV  >= 1 && LAT_INV  <= MAX_LAT);
      assert (LAT_SQRT >= 1 && LAT_SQRT <= MAX_LAT);
      assert (!(issue_fire && collide));
    end
  end
endmodule
